// File: rtl/dmem_pkg.sv
// Shared types for the data-side memory responder: FSM state encoding,
// latency ceiling and the latched request record.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int LAT_MAX = 15;

  // idx is the full 32-bit word offset from BASE; the responder only
  // uses the low ADDR_W bits to address the bank.
  typedef struct packed {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] idx;
    logic        oor;
  } req_t;

endpackage

// File: rtl/dmem_if.sv
// data_sram request/response bundle between the pipeline (master) and the
// memory responder (slave).
interface dmem_if;
  logic        req;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata, err
  );

  modport slave (
    input  req, wr, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata, err
  );
endinterface

// File: rtl/dmem_bank.sv
// Word memory with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module dmem_bank #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [2**ADDR_W];

  // Byte-masked write and registered read on the same edge.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      q <= mem[idx];
    end
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: accepts one request at a time, waits the
// configured latency, then performs the access on the edge entering RESP
// and pulses data_ok for one cycle with full-word read data and a
// range-error flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter int          LATENCY = 1,
  parameter logic [31:0] BASE    = 32'h1c000000
) (
  input logic   clk,
  input logic   resetn,
  dmem_if.slave bus
);

  // Out-of-range latency values are clamped into 1..LAT_MAX.
  localparam int LAT_EFF = (LATENCY < 1) ? 1 : ((LATENCY > LAT_MAX) ? LAT_MAX : LATENCY);
  localparam logic [3:0]  CNT_INIT = (LAT_EFF >= 2) ? 4'(LAT_EFF - 2) : 4'd0;
  localparam logic [31:0] DEPTH    = 32'd1 << ADDR_W;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        live, lat_q, src;
  logic        accept, resp_entry, bad;
  logic        rd_en;
  logic [3:0]  we;
  logic [31:0] q;
  logic        err_q;
  logic        rd_zero_q;
  logic [31:0] word_off;

  assign word_off = (bus.addr - BASE) >> 2;

  // Decode the incoming request; addresses below BASE wrap high and fail the range test.
  always_comb begin
    live.wr    = bus.wr;
    live.wstrb = bus.wstrb;
    live.wdata = bus.wdata;
    live.idx   = word_off;
    live.oor   = (word_off >= DEPTH);
  end

  assign accept = (state_q == IDLE) && bus.req;

  // Next-state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (LAT_EFF == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY==1 the RESP entry edge is the acceptance edge itself, so
  // the bank is fed straight from the bus while still in IDLE.
  always_comb begin
    src        = (state_q == IDLE) ? live : lat_q;
    bad        = src.oor | (|src.idx[31:ADDR_W]);
    resp_entry = resetn && (state_d == RESP) && (state_q != RESP);
    rd_en      = resp_entry && !src.wr && !bad;
    we         = (resp_entry && src.wr && !bad) ? src.wstrb : 4'b0000;
  end

  dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk   (clk),
    .rd_en (rd_en),
    .we    (we),
    .idx   (src.idx[ADDR_W-1:0]),
    .wdata (src.wdata),
    .q     (q)
  );

  // State, counter, latched request and response flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      lat_q     <= '0;
      err_q     <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        lat_q <= live;
      end
      if (resp_entry) begin
        err_q <= bad;
        // Write responses leave the read data untouched; range errors zero it.
        if (bad) begin
          rd_zero_q <= 1'b1;
        end else if (!src.wr) begin
          rd_zero_q <= 1'b0;
        end
      end
    end
  end

  assign bus.addr_ok = (state_q == IDLE);
  assign bus.data_ok = (state_q == RESP);
  assign bus.err     = err_q;
  assign bus.rdata   = rd_zero_q ? 32'd0 : q;

endmodule
